clk_period_monitor: RTL and testbench
=====================================

// Module: clk_period_monitor
// PURPOSE
//   Receive end of the divided-clock path: samples a slow clock (e.g. the divide-by-10
//   clk_div output) on the fast clk and measures its period and high time in clk cycles.
//   Declares lock after LOCK_CNT consecutive in-tolerance periods; flags mismatch and loss.
//   Sits beside each clock divider as a self-check / bring-up monitor.
// PARAMETERS
//   CNT_W      16  width of period/high-time counters and outputs
//   EXP_PERIOD 20  expected clk_in period in clk cycles (divide-by-10 toggle = 20)
//   TOL        1   allowed |period - EXP_PERIOD| for a match
//   LOCK_CNT   4   consecutive matching periods required to assert locked (>=1)
//   TIMEOUT    64  clk cycles without a clk_in rise before loss; must be < 2**CNT_W-1
// PORTS
//   clk          in   1      fast reference clock; all logic on posedge
//   reset        in   1      synchronous, active-high reset
//   enable       in   1      1 = monitor runs; 0 = idle
//   clk_in       in   1      slow clock under test, asynchronous to clk
//   period       out  CNT_W  last measured rise-to-rise period (clk cycles)
//   high_time    out  CNT_W  clk cycles clk_in was high in that period
//   period_valid out  1      1-cycle pulse: period/high_time updated
//   mismatch     out  1      1-cycle pulse with period_valid when period out of tolerance
//   locked       out  1      level: LOCK_CNT consecutive matches seen
//   timeout      out  1      sticky level: no rise within TIMEOUT cycles
// BEHAVIOUR
// - Reset (sync, active-high, priority over all): sync regs 0, state IDLE, cnt 0,
//   hcnt 0, match_cnt 0, all outputs 0.
// - Input: 2-FF synchroniser s1->s2, plus delay reg s3. rise = s2 & ~s3, fall = ~s2 & s3.
//   A clk_in edge sampled at edge N gives rise/fall at edge N+2.
// - FSM IDLE / ACQ / MEAS:
//   - IDLE: enable=1 -> ACQ with cnt=0.
//   - Any state, enable=0 -> IDLE next cycle; clears locked, timeout, match_cnt, cnt.
//     period and high_time hold.
//   - ACQ: cnt counts up every cycle. On rise: cnt<=1, hcnt<=1 -> MEAS, no period_valid.
//     The first partial period is never reported.
//   - MEAS: each cycle without rise: cnt<=cnt+1; if s2=1, hcnt<=hcnt+1.
//     On fall: hold hcnt as captured high time.
//     On rise: period<=cnt, high_time<=hcnt, period_valid=1, then cnt<=1, hcnt<=1.
//     cnt = clk cycles between successive rises exactly.
//   - Counters saturate at 2**CNT_W-1 and never wrap.
// - Match = (cnt >= EXP_PERIOD-TOL) && (cnt <= EXP_PERIOD+TOL), evaluated on the rise cycle.
//   Match: match_cnt++ (saturate at LOCK_CNT); locked<=1 on the same edge that raises
//   the LOCK_CNT-th period_valid.
//   No match: mismatch=1 with period_valid, match_cnt<=0, locked<=0 on that edge.
// - Timeout: in ACQ or MEAS, cnt reaches TIMEOUT without rise -> timeout<=1, locked<=0,
//   match_cnt<=0, state ACQ, cnt<=0. timeout stays 1 until next rise (cleared on that
//   edge) or enable=0/reset.
//   Rise and threshold in the same cycle: rise wins, no timeout.
// - period_valid and mismatch are never high for more than one consecutive cycle.
// - Reset or enable drop mid-period discards the partial measurement; no valid emitted.
// TESTING
// 1 clk_in toggles every 10 clk -> period=20, high_time=10 per valid; period_valid every
//   20 cycles; locked=1 with the 4th valid after the first rise; mismatch never 1.
// 2 Locked, then one period of 23 (high 13) -> period=23 with mismatch=1, locked 0 same edge;
//   4 further 20-cycle periods -> locked=1 again.
// 3 Periods of 19 and 21 -> match, no mismatch; period 22 -> mismatch.
// 4 Locked, clk_in held low -> timeout=1 and locked=0 exactly 64 cycles after last rise;
//   resume toggling -> timeout=0 on first rise, no valid; first valid one period later.
// 5 Reset pulsed mid-period while locked -> all outputs 0 next edge; measurement restarts,
//   first rise after reset produces no period_valid.
// 6 enable=0 for 5 cycles while locked -> locked=0, period holds; re-enable -> relock after
//   4 matching periods.

Source files
------------

// File: rtl/clk_period_monitor.sv
// Measures rise-to-rise period and high time of a slow clock sampled on clk.
// Reports lock after LOCK_CNT in-tolerance periods and flags mismatch and loss of clock.
module clk_period_monitor #(
    parameter int CNT_W      = 16,
    parameter int EXP_PERIOD = 20,
    parameter int TOL        = 1,
    parameter int LOCK_CNT   = 4,
    parameter int TIMEOUT    = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             clk_in,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic             period_valid,
    output logic             mismatch,
    output logic             locked,
    output logic             timeout
);

    typedef enum logic [1:0] {IDLE, ACQ, MEAS} state_t;

    localparam int MW = (LOCK_CNT < 1) ? 1 : $clog2(LOCK_CNT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] LO_LIM   = CNT_W'(EXP_PERIOD - TOL);
    localparam logic [CNT_W-1:0] HI_LIM   = CNT_W'(EXP_PERIOD + TOL);
    localparam logic [CNT_W-1:0] TO_LIM   = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [MW-1:0]    LOCK_LIM = MW'(LOCK_CNT);

    logic             s1_reg, s2_reg, s3_reg;
    state_t           state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [CNT_W-1:0] hcnt_reg, hcnt_next;
    logic [CNT_W-1:0] period_reg, period_next;
    logic [CNT_W-1:0] high_reg, high_next;
    logic [MW-1:0]    match_reg, match_next;
    logic             valid_reg, valid_next;
    logic             mism_reg, mism_next;
    logic             locked_reg, locked_next;
    logic             timeout_reg, timeout_next;

    logic             rise;
    logic             in_tol;
    logic             timed_out;
    logic [CNT_W-1:0] cnt_inc, hcnt_inc;
    logic [MW-1:0]    match_inc;

    assign rise      = s2_reg & ~s3_reg;
    assign in_tol    = (cnt_reg >= LO_LIM) && (cnt_reg <= HI_LIM);
    // A rise arriving on the threshold cycle takes precedence over loss detection
    assign timed_out = !rise && (cnt_reg >= TO_LIM);
    assign cnt_inc   = (cnt_reg == CNT_MAX) ? cnt_reg : cnt_reg + CNT_ONE;
    assign hcnt_inc  = (hcnt_reg == CNT_MAX) ? hcnt_reg : hcnt_reg + CNT_ONE;
    assign match_inc = (match_reg >= LOCK_LIM) ? LOCK_LIM : match_reg + MW'(1);

    always_comb begin
        state_next   = state_reg;
        cnt_next     = cnt_reg;
        hcnt_next    = hcnt_reg;
        period_next  = period_reg;
        high_next    = high_reg;
        match_next   = match_reg;
        valid_next   = 1'b0;
        mism_next    = 1'b0;
        locked_next  = locked_reg;
        timeout_next = timeout_reg;
        if (!enable) begin
            state_next   = IDLE;
            cnt_next     = '0;
            match_next   = '0;
            locked_next  = 1'b0;
            timeout_next = 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    state_next = ACQ;
                    cnt_next   = '0;
                end
                ACQ, MEAS: begin
                    if (rise) begin
                        // First rise after acquisition only aligns; the partial period is dropped
                        if (state_reg == MEAS) begin
                            period_next = cnt_reg;
                            high_next   = hcnt_reg;
                            valid_next  = 1'b1;
                            if (in_tol) begin
                                match_next  = match_inc;
                                locked_next = locked_reg | (match_inc == LOCK_LIM);
                            end else begin
                                mism_next   = 1'b1;
                                match_next  = '0;
                                locked_next = 1'b0;
                            end
                        end
                        state_next   = MEAS;
                        cnt_next     = CNT_ONE;
                        hcnt_next    = CNT_ONE;
                        timeout_next = 1'b0;
                    end else if (timed_out) begin
                        state_next   = ACQ;
                        cnt_next     = '0;
                        match_next   = '0;
                        locked_next  = 1'b0;
                        timeout_next = 1'b1;
                    end else begin
                        cnt_next = cnt_inc;
                        if (state_reg == MEAS && s2_reg) begin
                            hcnt_next = hcnt_inc;
                        end
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_reg      <= 1'b0;
            s2_reg      <= 1'b0;
            s3_reg      <= 1'b0;
            state_reg   <= IDLE;
            cnt_reg     <= '0;
            hcnt_reg    <= '0;
            period_reg  <= '0;
            high_reg    <= '0;
            match_reg   <= '0;
            valid_reg   <= 1'b0;
            mism_reg    <= 1'b0;
            locked_reg  <= 1'b0;
            timeout_reg <= 1'b0;
        end else begin
            s1_reg      <= clk_in;
            s2_reg      <= s1_reg;
            s3_reg      <= s2_reg;
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            hcnt_reg    <= hcnt_next;
            period_reg  <= period_next;
            high_reg    <= high_next;
            match_reg   <= match_next;
            valid_reg   <= valid_next;
            mism_reg    <= mism_next;
            locked_reg  <= locked_next;
            timeout_reg <= timeout_next;
        end
    end

    assign period       = period_reg;
    assign high_time    = high_reg;
    assign period_valid = valid_reg;
    assign mismatch     = mism_reg;
    assign locked       = locked_reg;
    assign timeout      = timeout_reg;

endmodule

// File: tb/tb_clk_period_monitor.sv
// Directed bench for clk_period_monitor: nominal lock, mismatch, tolerance edges,
// loss-of-clock timeout, mid-period reset and enable drop.
module tb_clk_period_monitor;
    localparam int CNT_W = 16;

    logic             clk = 1'b0;
    logic             reset;
    logic             enable;
    logic             clk_in;
    logic [CNT_W-1:0] period;
    logic [CNT_W-1:0] high_time;
    logic             period_valid;
    logic             mismatch;
    logic             locked;
    logic             timeout;

    int checks = 0;
    int failures = 0;

    int   cyc = 0;
    int   valid_n = 0;
    int   mism_n = 0;
    int   double_n = 0;
    int   orphan_n = 0;
    int   to_n = 0;
    int   last_period = 0;
    int   last_high = 0;
    int   last_valid_cyc = 0;
    int   to_cyc = 0;
    logic last_mism = 1'b0;
    logic last_locked = 1'b0;
    logic to_locked = 1'b0;
    logic prev_valid = 1'b0;
    logic prev_timeout = 1'b0;

    clk_period_monitor #(
        .CNT_W(CNT_W), .EXP_PERIOD(20), .TOL(1), .LOCK_CNT(4), .TIMEOUT(64)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable), .clk_in(clk_in),
        .period(period), .high_time(high_time), .period_valid(period_valid),
        .mismatch(mismatch), .locked(locked), .timeout(timeout)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Records every output event at the falling edge, away from the sampling edge
    always @(negedge clk) begin
        if (period_valid === 1'b1) begin
            valid_n++;
            last_period    = int'(period);
            last_high      = int'(high_time);
            last_mism      = mismatch;
            last_locked    = locked;
            last_valid_cyc = cyc;
            if (prev_valid === 1'b1) double_n++;
            $display("valid cyc=%0d period=%0d high=%0d mism=%0b locked=%0b",
                     cyc, period, high_time, mismatch, locked);
        end
        if (mismatch === 1'b1) begin
            mism_n++;
            if (period_valid !== 1'b1) orphan_n++;
        end
        if (timeout === 1'b1 && prev_timeout !== 1'b1) begin
            to_n++;
            to_cyc    = cyc;
            to_locked = locked;
            $display("timeout cyc=%0d locked=%0b", cyc, locked);
        end
        prev_valid   = period_valid;
        prev_timeout = timeout;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic gen(input int hi, input int lo);
        clk_in = 1'b1;
        repeat (hi) tick();
        clk_in = 1'b0;
        repeat (lo) tick();
    endtask

    task automatic test_reset();
        reset = 1'b1; enable = 1'b0; clk_in = 1'b0;
        repeat (3) tick();
        checks++; if (period !== 16'd0) begin failures++; $display("FAIL reset_period got=%0d exp=0", period); end
        checks++; if (high_time !== 16'd0) begin failures++; $display("FAIL reset_high got=%0d exp=0", high_time); end
        checks++; if ({period_valid, mismatch, locked, timeout} !== 4'b0000) begin
            failures++; $display("FAIL reset_flags got=%b exp=0000", {period_valid, mismatch, locked, timeout});
        end
        reset = 1'b0; enable = 1'b1;
        tick();
    endtask

    task automatic test_nominal();
        int base = valid_n;
        int base_m = mism_n;
        int prev_cyc = 0;
        gen(10, 10);
        checks++; if (valid_n !== base) begin failures++; $display("FAIL nominal_first_partial got=%0d exp=%0d", valid_n, base); end
        for (int k = 1; k <= 4; k++) begin
            gen(10, 10);
            checks++; if (valid_n !== base + k) begin failures++; $display("FAIL nominal_count k=%0d got=%0d exp=%0d", k, valid_n, base + k); end
            checks++; if (last_period !== 20 || last_high !== 10) begin
                failures++; $display("FAIL nominal_meas k=%0d got=%0d/%0d exp=20/10", k, last_period, last_high);
            end
            checks++; if (last_locked !== (k == 4)) begin failures++; $display("FAIL nominal_locked k=%0d got=%0b exp=%0b", k, last_locked, k == 4); end
            if (k > 1) begin
                checks++; if (last_valid_cyc - prev_cyc !== 20) begin
                    failures++; $display("FAIL nominal_spacing k=%0d got=%0d exp=20", k, last_valid_cyc - prev_cyc);
                end
            end
            prev_cyc = last_valid_cyc;
        end
        checks++; if (mism_n !== base_m) begin failures++; $display("FAIL nominal_no_mismatch got=%0d exp=%0d", mism_n - base_m, 0); end
    endtask

    task automatic test_mismatch();
        gen(13, 10);
        gen(10, 10);
        checks++; if (last_period !== 23 || last_high !== 13) begin
            failures++; $display("FAIL mism_meas got=%0d/%0d exp=23/13", last_period, last_high);
        end
        checks++; if (last_mism !== 1'b1 || last_locked !== 1'b0) begin
            failures++; $display("FAIL mism_flags got mism=%0b locked=%0b exp mism=1 locked=0", last_mism, last_locked);
        end
        for (int k = 1; k <= 4; k++) begin
            gen(10, 10);
            checks++; if (last_period !== 20 || last_mism !== 1'b0 || last_locked !== (k == 4)) begin
                failures++; $display("FAIL mism_relock k=%0d got=%0d/%0b/%0b exp=20/0/%0b", k, last_period, last_mism, last_locked, k == 4);
            end
        end
    endtask

    task automatic test_tolerance();
        gen(10, 9);
        gen(11, 10);
        checks++; if (last_period !== 19 || last_high !== 10 || last_mism !== 1'b0) begin
            failures++; $display("FAIL tol_19 got=%0d/%0d/%0b exp=19/10/0", last_period, last_high, last_mism);
        end
        gen(11, 11);
        checks++; if (last_period !== 21 || last_high !== 11 || last_mism !== 1'b0) begin
            failures++; $display("FAIL tol_21 got=%0d/%0d/%0b exp=21/11/0", last_period, last_high, last_mism);
        end
        gen(10, 10);
        checks++; if (last_period !== 22 || last_high !== 11 || last_mism !== 1'b1 || last_locked !== 1'b0) begin
            failures++; $display("FAIL tol_22 got=%0d/%0d/%0b/%0b exp=22/11/1/0", last_period, last_high, last_mism, last_locked);
        end
    endtask

    task automatic test_timeout();
        int base_to;
        int base_v;
        repeat (4) gen(10, 10);
        checks++; if (locked !== 1'b1) begin failures++; $display("FAIL to_prelock got=%0b exp=1", locked); end
        base_to = to_n;
        clk_in = 1'b0;
        for (int i = 0; i < 200 && to_n == base_to; i++) tick();
        tick();
        checks++; if (to_n !== base_to + 1) begin failures++; $display("FAIL to_seen got=%0d exp=%0d", to_n, base_to + 1); end
        checks++; if (to_cyc - last_valid_cyc !== 64) begin
            failures++; $display("FAIL to_delay got=%0d exp=64", to_cyc - last_valid_cyc);
        end
        checks++; if (to_locked !== 1'b0 || timeout !== 1'b1) begin
            failures++; $display("FAIL to_flags got locked=%0b timeout=%0b exp locked=0 timeout=1", to_locked, timeout);
        end
        base_v = valid_n;
        gen(10, 10);
        checks++; if (timeout !== 1'b0 || valid_n !== base_v) begin
            failures++; $display("FAIL to_resume got timeout=%0b valids=%0d exp timeout=0 valids=%0d", timeout, valid_n, base_v);
        end
        gen(10, 10);
        checks++; if (valid_n !== base_v + 1 || last_period !== 20 || last_high !== 10) begin
            failures++; $display("FAIL to_first_valid got=%0d/%0d/%0d exp=%0d/20/10", valid_n, last_period, last_high, base_v + 1);
        end
    endtask

    task automatic test_reset_mid();
        int base_v;
        repeat (3) gen(10, 10);
        checks++; if (locked !== 1'b1) begin failures++; $display("FAIL rst_prelock got=%0b exp=1", locked); end
        clk_in = 1'b1;
        repeat (10) tick();
        clk_in = 1'b0;
        repeat (5) tick();
        reset = 1'b1;
        tick();
        checks++; if (period !== 16'd0 || high_time !== 16'd0) begin
            failures++; $display("FAIL rst_mid_meas got=%0d/%0d exp=0/0", period, high_time);
        end
        checks++; if ({period_valid, mismatch, locked, timeout} !== 4'b0000) begin
            failures++; $display("FAIL rst_mid_flags got=%b exp=0000", {period_valid, mismatch, locked, timeout});
        end
        reset = 1'b0;
        base_v = valid_n;
        repeat (4) tick();
        gen(10, 10);
        checks++; if (valid_n !== base_v) begin failures++; $display("FAIL rst_first_rise got=%0d exp=%0d", valid_n, base_v); end
        gen(10, 10);
        checks++; if (valid_n !== base_v + 1 || last_period !== 20 || last_locked !== 1'b0) begin
            failures++; $display("FAIL rst_restart got=%0d/%0d/%0b exp=%0d/20/0", valid_n, last_period, last_locked, base_v + 1);
        end
    endtask

    task automatic test_enable();
        int base_v;
        repeat (3) gen(10, 10);
        checks++; if (locked !== 1'b1) begin failures++; $display("FAIL en_prelock got=%0b exp=1", locked); end
        clk_in = 1'b1;
        repeat (10) tick();
        clk_in = 1'b0;
        repeat (3) tick();
        base_v = valid_n;
        enable = 1'b0;
        repeat (5) tick();
        checks++; if (locked !== 1'b0 || timeout !== 1'b0) begin
            failures++; $display("FAIL en_off_flags got locked=%0b timeout=%0b exp 0/0", locked, timeout);
        end
        checks++; if (period !== 16'd20 || high_time !== 16'd10) begin
            failures++; $display("FAIL en_off_hold got=%0d/%0d exp=20/10", period, high_time);
        end
        enable = 1'b1;
        repeat (7) tick();
        gen(10, 10);
        checks++; if (valid_n !== base_v) begin failures++; $display("FAIL en_first_rise got=%0d exp=%0d", valid_n, base_v); end
        for (int k = 1; k <= 4; k++) begin
            gen(10, 10);
            checks++; if (last_period !== 20 || last_locked !== (k == 4)) begin
                failures++; $display("FAIL en_relock k=%0d got=%0d/%0b exp=20/%0b", k, last_period, last_locked, k == 4);
            end
        end
    endtask

    task automatic test_back_to_back();
        checks++; if (double_n !== 0) begin failures++; $display("FAIL pulse_width got=%0d exp=0", double_n); end
        checks++; if (orphan_n !== 0) begin failures++; $display("FAIL mism_without_valid got=%0d exp=0", orphan_n); end
    endtask

    initial begin
        reset = 1'b1;
        enable = 1'b0;
        clk_in = 1'b0;
        test_reset();
        test_nominal();
        test_mismatch();
        test_tolerance();
        test_timeout();
        test_reset_mid();
        test_enable();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
